uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel receive stage for the UART; consumes the line produced by uart_transmitter (same framing: 1 start bit, 5–8 data bits LSB-first, 1 stop bit, no parity).
- Runs on the system clock and oversamples rx using a 16x baud tick enable.
- Presents the received character in a UDR-style holding register with RXC/FE/DOR status flags for the CPU register interface.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be a power of two, at least 8.
- MIN_CHAR, 5, smallest legal char_size.
- MAX_CHAR, 8, largest legal char_size; also the data_out width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- baud_tick  in  1  one-clk pulse, OVERSAMPLE times per bit period.
- char_size  in  4  data bits per character.
- re  in  1  receiver enable.
- rd  in  1  one-clk strobe: CPU read of data_out; clears status flags.
- data_out  out  8  last accepted character, zero-extended above char_size.
- rxc  out  1  receive complete; character waiting in data_out.
- fe  out  1  frame error; stop bit of the accepted character sampled 0.
- dor  out  1  data overrun; a character was lost because rxc was still set.
- rx_busy  out  1  frame in progress (state is not IDLE).

Behaviour:
- Reset is asynchronous. All outputs are 0, the synchronizer is 1, state is IDLE, and the counters are 0.
- rx passes through a 2-flop synchronizer (rx_s) before any use. Pin-to-logic latency is 2 clk.
- Effective char_size: values below 5 are treated as 5, values above 8 as 8. It is sampled on entry to DATA and held for the frame.
- All sampling and counting happen only on cycles where baud_tick=1. tick_cnt is log2(OVERSAMPLE) bits.
- State machine:
  - IDLE: arms only after rx_s has been seen as 1 on a tick, so a continuous break does not retrigger. With re=1, armed, and rx_s=0 on a tick: tick_cnt←0, go to START.
  - START: at tick_cnt=OVERSAMPLE/2−1 (mid start bit), sample rx_s. If 1: false start, go to IDLE with no flags. If 0: tick_cnt←0, bit_idx←0, go to DATA.
  - DATA: at tick_cnt=OVERSAMPLE−1, store rx_s in shift[bit_idx] and increment bit_idx. After the sample where bit_idx=size−1, go to STOP.
  - STOP: at tick_cnt=OVERSAMPLE−1, sample the stop bit, then accept (below) and go to IDLE, disarmed.
- Accept, when rxc=0 or rd=1 on the same cycle:
  - data_out←shift with bits ≥ size forced to 0.
  - rxc←1; fe←(stop==0); dor←0.
- Accept, when rxc=1 and rd=0:
  - data_out and fe are unchanged; dor←1; rxc stays 1.
- rd=1 with no accept on that cycle: rxc, fe and dor clear on the next edge. data_out holds its value.
- re=0 in any non-IDLE state aborts to IDLE on the next edge. Partial data is discarded and flags are unchanged. re=0 in IDLE blocks start detection.
- rx_busy=1 exactly while state is START, DATA or STOP.
- Reset asserted mid-frame restores all reset values immediately. The frame is lost and no flags are set.

Decomposition:
- Package uart_pkg:
  - state encoding: STATE_IDLE, STATE_START, STATE_SEND/DATA, STATE_STOP.
  - LINE_IDLE=1 and LINE_START=0.
  - CHAR_MIN=5 and CHAR_MAX=8.
  - OVERSAMPLE default.
  - Shared with uart_transmitter.
- Sub-module uart_rx_sync: 2-flop synchronizer with async reset to 1. Reusable for other async inputs.

Test Plan (baud_tick every 4 clk, OVERSAMPLE=16):
- char_size=8, re=1, send 0x55 with stop=1 → after the stop mid-sample, data_out=0x55, rxc=1, fe=0, dor=0. rx_busy is high from the start edge through STOP. Then rd pulse → rxc=0, data_out still 0x55.
- char_size=5, send 5 bits 0x1B, then stop → data_out=0x1B, upper bits 0. Repeat with char_size=3 → treated as 5, same result.
- rx low for 4 ticks, then high (glitch) → returns to IDLE; rxc, fe and dor stay 0; rx_busy pulses only briefly.
- char_size=8, send 0xA3 with stop bit=0 → data_out=0xA3, rxc=1, fe=1. After rd, fe=0.
- Receive 0x11 and do not read, then receive 0x22 → data_out=0x11, rxc=1, dor=1. Then rd → all flags 0. Then receive 0x33 with rd asserted on its accept cycle → data_out=0x33, rxc=1, dor=0.
- Assert rst during DATA bit 3 → all outputs 0 within the same cycle, with no clock edge needed. After release, a clean 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, character-size limits and FSM state encoding.
// Used by both uart_transmitter and uart_receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_START,
    STATE_DATA,
    STATE_STOP
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int unsigned CHAR_MIN           = 5;
  localparam int unsigned CHAR_MAX           = 8;
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input.
// Resets to the idle line level so a reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= LINE_IDLE;
      q    <= LINE_IDLE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receive stage: start/data/stop framing with a UDR-style holding
// register and RXC/FE/DOR status flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int unsigned MIN_CHAR   = CHAR_MIN,
  parameter int unsigned MAX_CHAR   = CHAR_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic                baud_tick,
  input  logic [3:0]          char_size,
  input  logic                re,
  input  logic                rd,
  output logic [MAX_CHAR-1:0] data_out,
  output logic                rxc,
  output logic                fe,
  output logic                dor,
  output logic                rx_busy
);

  localparam int unsigned     TickW   = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] TickMid = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickEnd = TickW'(OVERSAMPLE - 1);

  logic                rx_s;
  uart_state_e         state_q, state_d;
  logic                armed_q, armed_d;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [3:0]          bit_idx_q, bit_idx_d;
  logic [3:0]          size_q, size_d, size_in;
  logic [MAX_CHAR-1:0] shift_q, shift_d;
  logic [MAX_CHAR-1:0] data_q, data_d, masked;
  logic                rxc_q, rxc_d, fe_q, fe_d, dor_q, dor_d;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    if (char_size < 4'(MIN_CHAR)) begin
      size_in = 4'(MIN_CHAR);
    end else if (char_size > 4'(MAX_CHAR)) begin
      size_in = 4'(MAX_CHAR);
    end else begin
      size_in = char_size;
    end
  end

  // Stale bits from a longer previous frame must not leak into a shorter character.
  always_comb begin
    masked = '0;
    for (int i = 0; i < MAX_CHAR; i++) begin
      if (4'(i) < size_q) masked[i] = shift_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    size_d    = size_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rxc_d     = rxc_q;
    fe_d      = fe_q;
    dor_d     = dor_q;

    if (rd) begin
      rxc_d = 1'b0;
      fe_d  = 1'b0;
      dor_d = 1'b0;
    end

    if (state_q != STATE_IDLE && !re) begin
      state_d = STATE_IDLE;
      armed_d = 1'b0;
    end else if (baud_tick) begin
      case (state_q)
        STATE_IDLE: begin
          // Arming requires a seen-high line so a held break cannot retrigger.
          if (rx_s == LINE_IDLE) armed_d = 1'b1;
          if (re && armed_q && rx_s == LINE_START) begin
            tick_d  = '0;
            state_d = STATE_START;
          end
        end
        STATE_START: begin
          if (tick_q == TickMid) begin
            if (rx_s == LINE_IDLE) begin
              state_d = STATE_IDLE;
            end else begin
              tick_d    = '0;
              bit_idx_d = '0;
              size_d    = size_in;
              state_d   = STATE_DATA;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STATE_DATA: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TickEnd) begin
            for (int i = 0; i < MAX_CHAR; i++) begin
              if (bit_idx_q == 4'(i)) shift_d[i] = rx_s;
            end
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == size_q - 4'd1) state_d = STATE_STOP;
          end
        end
        STATE_STOP: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TickEnd) begin
            state_d = STATE_IDLE;
            armed_d = 1'b0;
            if (!rxc_q || rd) begin
              data_d = masked;
              rxc_d  = 1'b1;
              fe_d   = (rx_s == LINE_START);
              dor_d  = 1'b0;
            end else begin
              dor_d = 1'b1;
            end
          end
        end
        default: state_d = STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= STATE_IDLE;
      armed_q   <= 1'b0;
      tick_q    <= '0;
      bit_idx_q <= '0;
      size_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rxc_q     <= 1'b0;
      fe_q      <= 1'b0;
      dor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      size_q    <= size_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rxc_q     <= rxc_d;
      fe_q      <= fe_d;
      dor_q     <= dor_d;
    end
  end

  assign data_out = data_q;
  assign rxc      = rxc_q;
  assign fe       = fe_q;
  assign dor      = dor_q;
  assign rx_busy  = (state_q != STATE_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames,
// checked against a character-level model of the receive register and flags.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst, rx, baud_tick, re, rd;
  logic [3:0] char_size;
  logic [7:0] data_out;
  logic       rxc, fe, dor, rx_busy;

  int vectors = 0;
  int errors  = 0;

  // Character-level model of the CPU-visible register and flags.
  logic [7:0] exp_data;
  logic       exp_rxc, exp_fe, exp_dor;

  int tick_phase = 0;

  uart_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .baud_tick (baud_tick),
    .char_size (char_size),
    .re        (re),
    .rd        (rd),
    .data_out  (data_out),
    .rxc       (rxc),
    .fe        (fe),
    .dor       (dor),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // baud_tick is valid for the coming posedge; updated mid-high-phase to avoid races.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick_phase = (tick_phase + 1) % 4;
      baud_tick  = (tick_phase == 0);
    end
  end

  function automatic int eff_size(input logic [3:0] cs);
    if (cs < 4'd5) return 5;
    if (cs > 4'd8) return 8;
    return int'(cs);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Leaves us at the negedge just before a ticking posedge.
  task automatic align();
    do @(negedge clk); while (!baud_tick);
  endtask

  task automatic do_read();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    exp_rxc = 1'b0;
    exp_fe  = 1'b0;
    exp_dor = 1'b0;
  endtask

  // Sends one frame of eff_size(char_size) bits. With rx falling right before tick posedge P0,
  // detection lands on P4, mid-start on P36, data bit i on P100+64i, stop/accept on P100+64n.
  task automatic send_frame(input logic [7:0] value, input logic stop_bit,
                            input bit rd_at_accept, output bit busy_ok);
    int n, acc, len, k;
    logic [7:0] mask;
    n       = eff_size(char_size);
    acc     = 100 + 64 * n;
    len     = 64 * (n + 2);
    busy_ok = 1'b1;
    align();
    for (int c = 0; c < len; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (rx_busy !== (c >= 5 && c <= acc)) busy_ok = 1'b0;
      end
      k  = c / 64;
      rx = (k == 0) ? 1'b0 : (k <= n) ? value[k-1] : stop_bit;
      rd = rd_at_accept && (c == acc);
    end
    @(negedge clk);
    rd = 1'b0;
    rx = 1'b1;
    idle(16);
    mask = 8'hFF >> (8 - n);
    if (!exp_rxc || rd_at_accept) begin
      exp_data = value & mask;
      exp_rxc  = 1'b1;
      exp_fe   = !stop_bit;
      exp_dor  = 1'b0;
    end else begin
      exp_dor = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; re = 1'b1; rd = 1'b0; char_size = 4'd8;
    exp_data = '0; exp_rxc = 1'b0; exp_fe = 1'b0; exp_dor = 1'b0;
    #1;
    vectors++;
    if ({data_out, rxc, fe, dor, rx_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got data=%h rxc=%b fe=%b dor=%b busy=%b, want all 0",
               data_out, rxc, fe, dor, rx_busy);
    end
    idle(3);
    rst = 1'b0;
    idle(16);
    vectors++;
    if ({data_out, rxc, fe, dor, rx_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release: got data=%h rxc=%b fe=%b dor=%b busy=%b, want all 0",
               data_out, rxc, fe, dor, rx_busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    char_size = 4'd8;
    send_frame(8'h55, 1'b1, 1'b0, ok);
    vectors++;
    if ({data_out, rxc, fe, dor} !== {exp_data, exp_rxc, exp_fe, exp_dor}) begin
      errors++;
      $display("FAIL basic_55: got data=%h rxc=%b fe=%b dor=%b, want data=%h rxc=%b fe=%b dor=%b",
               data_out, rxc, fe, dor, exp_data, exp_rxc, exp_fe, exp_dor);
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_busy: rx_busy window wrong, got ok=0 want ok=1");
    end
    do_read();
    vectors++;
    if ({data_out, rxc, fe, dor} !== {8'h55, 3'b000}) begin
      errors++;
      $display("FAIL basic_read: got data=%h rxc=%b fe=%b dor=%b, want data=55 flags 0",
               data_out, rxc, fe, dor);
    end
  endtask

  task automatic test_short_char();
    bit ok;
    logic [3:0] sizes [2];
    sizes[0] = 4'd5;
    sizes[1] = 4'd3;
    for (int s = 0; s < 2; s++) begin
      // Preload the shift register's upper bits with ones.
      char_size = 4'd8;
      send_frame(8'hE0, 1'b1, 1'b0, ok);
      do_read();
      char_size = sizes[s];
      send_frame(8'h1B, 1'b1, 1'b0, ok);
      vectors++;
      if ({data_out, rxc, fe, dor} !== {8'h1B, 3'b100} ||
          {data_out, rxc, fe, dor} !== {exp_data, exp_rxc, exp_fe, exp_dor}) begin
        errors++;
        $display("FAIL short_char cs=%0d: got data=%h rxc=%b fe=%b dor=%b, want data=1b rxc=1",
                 sizes[s], data_out, rxc, fe, dor);
      end
      vectors++;
      if (!ok) begin
        errors++;
        $display("FAIL short_busy cs=%0d: rx_busy window wrong, got ok=0 want ok=1", sizes[s]);
      end
      do_read();
    end
  endtask

  task automatic test_glitch();
    int busy_cnt = 0;
    align();
    for (int c = 0; c < 100; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (rx_busy) busy_cnt++;
      end
      rx = (c < 16) ? 1'b0 : 1'b1;
    end
    vectors++;
    if (busy_cnt != 32) begin
      errors++;
      $display("FAIL glitch_busy: got %0d busy cycles, want 32", busy_cnt);
    end
    vectors++;
    if ({data_out, rxc, fe, dor, rx_busy} !== {exp_data, exp_rxc, exp_fe, exp_dor, 1'b0}) begin
      errors++;
      $display("FAIL glitch_flags: got data=%h rxc=%b fe=%b dor=%b busy=%b, want data=%h flags 0",
               data_out, rxc, fe, dor, rx_busy, exp_data);
    end
  endtask

  task automatic test_frame_error();
    bit ok;
    char_size = 4'd8;
    send_frame(8'hA3, 1'b0, 1'b0, ok);
    vectors++;
    if ({data_out, rxc, fe, dor} !== {8'hA3, 3'b110}) begin
      errors++;
      $display("FAIL frame_error: got data=%h rxc=%b fe=%b dor=%b, want data=a3 rxc=1 fe=1 dor=0",
               data_out, rxc, fe, dor);
    end
    do_read();
    vectors++;
    if ({rxc, fe, dor} !== 3'b000) begin
      errors++;
      $display("FAIL fe_clear: got rxc=%b fe=%b dor=%b, want 000", rxc, fe, dor);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    char_size = 4'd8;
    send_frame(8'h11, 1'b1, 1'b0, ok);
    send_frame(8'h22, 1'b1, 1'b0, ok);
    vectors++;
    if ({data_out, rxc, fe, dor} !== {8'h11, 3'b101}) begin
      errors++;
      $display("FAIL overrun: got data=%h rxc=%b fe=%b dor=%b, want data=11 rxc=1 fe=0 dor=1",
               data_out, rxc, fe, dor);
    end
    do_read();
    vectors++;
    if ({rxc, fe, dor} !== 3'b000) begin
      errors++;
      $display("FAIL dor_clear: got rxc=%b fe=%b dor=%b, want 000", rxc, fe, dor);
    end
    send_frame(8'h44, 1'b1, 1'b0, ok);
    send_frame(8'h33, 1'b1, 1'b1, ok);
    vectors++;
    if ({data_out, rxc, fe, dor} !== {8'h33, 3'b100}) begin
      errors++;
      $display("FAIL rd_on_accept: got data=%h rxc=%b fe=%b dor=%b, want data=33 rxc=1 dor=0",
               data_out, rxc, fe, dor);
    end
    do_read();
  endtask

  task automatic test_abort();
    int busy_cnt = 0;
    char_size = 4'd8;
    align();
    for (int c = 0; c <= 200; c++) begin
      if (c > 0) @(negedge clk);
      rx = (c < 64) ? 1'b0 : c[6];
      if (c == 200) begin
        vectors++;
        if (rx_busy !== 1'b1) begin
          errors++;
          $display("FAIL abort_pre: got busy=%b, want 1", rx_busy);
        end
        re = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b, want 0", rx_busy);
    end
    rx = 1'b1;
    idle(16);
    // Receiver disabled: a full start bit must not begin a frame.
    rx = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    rx = 1'b1;
    idle(16);
    vectors++;
    if (busy_cnt != 0) begin
      errors++;
      $display("FAIL re_block: got %0d busy cycles, want 0", busy_cnt);
    end
    re = 1'b1;
    idle(16);
    vectors++;
    if ({data_out, rxc, fe, dor} !== {exp_data, exp_rxc, exp_fe, exp_dor}) begin
      errors++;
      $display("FAIL abort_flags: got data=%h rxc=%b fe=%b dor=%b, want data=%h rxc=%b fe=%b dor=%b",
               data_out, rxc, fe, dor, exp_data, exp_rxc, exp_fe, exp_dor);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    char_size = 4'd8;
    send_frame(8'h5A, 1'b1, 1'b0, ok);
    align();
    for (int c = 0; c <= 300; c++) begin
      if (c > 0) @(negedge clk);
      rx = (c < 64) ? 1'b0 : 1'b1;
    end
    #2;
    rst = 1'b1;
    #1;
    exp_data = '0; exp_rxc = 1'b0; exp_fe = 1'b0; exp_dor = 1'b0;
    vectors++;
    if ({data_out, rxc, fe, dor, rx_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_async: got data=%h rxc=%b fe=%b dor=%b busy=%b, want all 0",
               data_out, rxc, fe, dor, rx_busy);
    end
    idle(3);
    rst = 1'b0;
    rx  = 1'b1;
    idle(16);
    send_frame(8'h7E, 1'b1, 1'b0, ok);
    vectors++;
    if ({data_out, rxc, fe, dor} !== {8'h7E, 3'b100} || !ok) begin
      errors++;
      $display("FAIL reset_recover: got data=%h rxc=%b fe=%b dor=%b busy_ok=%b, want data=7e rxc=1",
               data_out, rxc, fe, dor, ok);
    end
    do_read();
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] value;
    logic stop_bit;
    bit rd_acc;
    for (int t = 0; t < 20; t++) begin
      char_size = 4'($urandom_range(0, 15));
      value     = 8'($urandom);
      stop_bit  = ($urandom_range(0, 3) != 0);
      rd_acc    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) do_read();
      send_frame(value, stop_bit, rd_acc, ok);
      vectors++;
      if ({data_out, rxc, fe, dor} !== {exp_data, exp_rxc, exp_fe, exp_dor} || !ok) begin
        errors++;
        $display("FAIL random_%0d cs=%0d v=%h: got data=%h rxc=%b fe=%b dor=%b busy_ok=%b, want data=%h rxc=%b fe=%b dor=%b",
                 t, char_size, value, data_out, rxc, fe, dor, ok,
                 exp_data, exp_rxc, exp_fe, exp_dor);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_char();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
